div_result_writeback: RTL and testbench
=======================================

Name: div_result_writeback

Overview:
- Downstream stage of the 32-bit divider. Accepts each quotient/remainder pair through a valid/ready handshake and buffers it in a small FIFO.
- Serializes each pair onto the 32-bit datapath bus in two beats: LO (quotient) first, then HI (remainder).
- Updates the architectural LO/HI registers as each beat is accepted.
- Keeps a sticky divide-by-zero status flag.

Parameters:
- WIDTH, 32, data width of quotient, remainder, bus and HI/LO.
- DEPTH, 2, FIFO entries (power of 2, >= 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  divider result present.
- in_ready  out  1  block can accept a result this cycle.
- in_q  in  WIDTH  quotient.
- in_r  in  WIDTH  remainder.
- in_dz  in  1  divisor was zero for this result.
- out_valid  out  1  bus beat valid.
- out_ready  in  1  bus consumer accepts beat.
- out_data  out  WIDTH  beat payload.
- out_sel  out  1  0 = LO beat, 1 = HI beat.
- out_last  out  1  high on the HI beat (equals out_sel when out_valid).
- lo  out  WIDTH  architectural LO register.
- hi  out  WIDTH  architectural HI register.
- dz_flag  out  1  sticky divide-by-zero status.
- dz_clear  in  1  clears dz_flag.
- count  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: FIFO empty, count=0, beat state = SEND_LO, out_valid=0, out_sel=0, out_last=0, out_data=0, lo=0, hi=0, dz_flag=0.
- Reset mid-operation:
  - Discards all buffered entries and any half-sent pair.
  - Beat state returns to SEND_LO.
  - Reset has priority over every other input.
- Input side:
  - in_ready = (count != DEPTH); there is no pop-to-push bypass when full.
  - Push happens when in_valid && in_ready.
  - The stored entry is {dz, r, q'}, where q' = all-ones if in_dz, else in_q. The remainder is stored unchanged in both cases.
- FIFO:
  - Circular, with read/write pointers that wrap modulo DEPTH.
  - An entry pushed at cycle N first appears at the output at cycle N+1 (1-cycle latency, registered).
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Output state machine (operates on the head entry):
  - out_valid = (count != 0).
  - SEND_LO: out_data = head q', out_sel=0, out_last=0.
    - On out_valid && out_ready: lo <= q'; if head dz, dz_flag <= 1; go to SEND_HI.
  - SEND_HI: out_data = head r, out_sel=1, out_last=1.
    - On out_ready: hi <= r; pop head; go to SEND_LO.
  - While out_ready=0: out_valid and out_data hold stable, with no change to lo, hi or state.
  - The state machine never leaves SEND_HI without the pop, so a pair is never split across entries.
  - Back-to-back pairs: the next entry's LO beat starts in the cycle after the HI handshake, with no bubble.
- Status flag:
  - dz_clear and a dz set in the same cycle: set wins, dz_flag = 1.
  - Otherwise dz_clear forces dz_flag to 0.
- Width rules:
  - No arithmetic on the data.
  - count is computed with the extra MSB so that full and empty are distinguished.
- Constraints on inputs: in_q, in_r and in_dz are sampled only on push; values at other times are don't-care.

Test Plan:
- Reset, then push q=0x00000007, r=0x00000002 with out_ready=1:
  - cycle+1: out_valid=1, out_sel=0, out_data=0x7.
  - cycle+2: out_sel=1, out_data=0x2, out_last=1.
  - Afterwards: lo=0x7, hi=0x2, count=0.
- Push 3 results back-to-back with out_ready=0 and DEPTH=2:
  - in_ready drops after the 2nd push and count=2.
  - The 3rd result is held off until the first HI beat is accepted.
  - Beats then arrive LO1, HI1, LO2, HI2, LO3, HI3 in order, with no bubble.
- Push with in_dz=1, r=0x0000000A:
  - LO beat = 0xFFFFFFFF, then HI = 0xA.
  - dz_flag=1 after the LO accept.
  - Asserting dz_clear in the same cycle as a second dz LO accept leaves dz_flag=1.
  - dz_clear alone then gives dz_flag=0.
- Stall in the middle of a pair: accept the LO beat (lo updates), hold out_ready=0 for 5 cycles.
  - HI beat data stays stable and hi is unchanged throughout.
  - hi updates on the cycle out_ready=1.
- Assert rst while in SEND_HI with count=2:
  - Next cycle: count=0, out_valid=0, lo=hi=0, dz_flag=0, in_ready=1.
  - A following push serializes from the LO beat.
- Simultaneous push and pop at count=1 (HI handshake plus in_valid): count stays 1, and pointer wrap-around is exercised over 8 pairs with data integrity checked.

Source files
------------

// File: rtl/div_result_writeback.sv
// div_result_writeback: buffers divider results (quotient, remainder,
// divide-by-zero) in a small circular FIFO and serializes each result onto
// the datapath bus as two beats, LO (quotient) then HI (remainder). It also
// updates the architectural LO/HI registers and a sticky divide-by-zero flag.
module div_result_writeback #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_q,
  input  logic [WIDTH-1:0]         in_r,
  input  logic                     in_dz,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sel,
  output logic                     out_last,
  output logic [WIDTH-1:0]         lo,
  output logic [WIDTH-1:0]         hi,
  output logic                     dz_flag,
  input  logic                     dz_clear,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    SEND_LO = 1'b0,
    SEND_HI = 1'b1
  } beat_state_t;

  beat_state_t r_state;
  beat_state_t w_state_next;

  // Entry layout: {dz, remainder, quotient-as-sent}
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_dz_flag;

  logic             w_push;
  logic             w_pop;
  logic             w_lo_acc;
  logic [WIDTH-1:0] w_q_store;
  logic [EW-1:0]    w_entry;
  logic [EW-1:0]    w_head;
  logic [WIDTH-1:0] w_head_q;
  logic [WIDTH-1:0] w_head_r;
  logic             w_head_dz;
  logic             w_dz_set;

  // A divide-by-zero result reports an all-ones quotient; the remainder
  // passes through untouched.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_q_force
      assign w_q_store[gi] = in_q[gi] | in_dz;
    end
  endgenerate

  assign w_entry   = {in_dz, in_r, w_q_store};
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_q  = w_head[WIDTH-1:0];
  assign w_head_r  = w_head[2*WIDTH-1:WIDTH];
  assign w_head_dz = w_head[EW-1];

  // No pop-to-push bypass: a full FIFO refuses input even while popping.
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_dz_set  = w_lo_acc && w_head_dz;

  assign count   = r_count;
  assign lo      = r_lo;
  assign hi      = r_hi;
  assign dz_flag = r_dz_flag;

  // FIFO storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Beat state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEND_LO;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Beat sequencing and bus outputs for the head entry; the pop happens only
  // on the HI handshake so a pair is never split.
  always_comb begin
    w_state_next = r_state;
    out_data     = '0;
    out_sel      = 1'b0;
    out_last     = 1'b0;
    w_lo_acc     = 1'b0;
    w_pop        = 1'b0;
    if (out_valid) begin
      case (r_state)
        SEND_LO: begin
          out_data = w_head_q;
          if (out_ready) begin
            w_lo_acc     = 1'b1;
            w_state_next = SEND_HI;
          end
        end
        SEND_HI: begin
          out_data = w_head_r;
          out_sel  = 1'b1;
          out_last = 1'b1;
          if (out_ready) begin
            w_pop        = 1'b1;
            w_state_next = SEND_LO;
          end
        end
        default: begin
          w_state_next = SEND_LO;
        end
      endcase
    end
  end

  // Architectural LO/HI update as each beat is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      if (w_lo_acc) begin
        r_lo <= w_head_q;
      end
      if (w_pop) begin
        r_hi <= w_head_r;
      end
    end
  end

  // Sticky divide-by-zero flag; a new set beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dz_flag <= 1'b0;
    end else if (w_dz_set) begin
      r_dz_flag <= 1'b1;
    end else if (dz_clear) begin
      r_dz_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_result_writeback.sv
// Testbench for div_result_writeback: directed scenarios plus randomized
// traffic, all compared cycle by cycle with a queue-based transaction model.
module tb_div_result_writeback;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] in_r;
  logic             in_dz;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_last;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             dz_flag;
  logic             dz_clear;
  logic [CW-1:0]    count;

  div_result_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_q      (in_q),
    .in_r      (in_r),
    .in_dz     (in_dz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .lo        (lo),
    .hi        (hi),
    .dz_flag   (dz_flag),
    .dz_clear  (dz_clear),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;

  // Transaction model: queued results plus whether the head's LO beat went out.
  logic [WIDTH-1:0] m_q [$];
  logic [WIDTH-1:0] m_r [$];
  bit               m_dz [$];
  bit               m_half;
  logic [WIDTH-1:0] m_lo;
  logic [WIDTH-1:0] m_hi;
  bit               m_dzf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_r.delete();
    m_dz.delete();
    m_half = 1'b0;
    m_lo   = '0;
    m_hi   = '0;
    m_dzf  = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, then
  // advance the model by what the coming rising edge should do.
  task automatic step(input bit v, input logic [31:0] q, input logic [31:0] r, input bit dz,
                      input bit rdy, input bit clr, input bit rs);
    bit exp_valid;
    bit exp_ready;
    bit lo_acc;
    bit hi_acc;
    @(negedge clk);
    in_valid  = v;
    in_q      = q;
    in_r      = r;
    in_dz     = dz;
    out_ready = rdy;
    dz_clear  = clr;
    rst       = rs;
    #1;
    exp_valid = (m_q.size() != 0);
    exp_ready = (m_q.size() < DEPTH);
    check_val("in_ready", in_ready, exp_ready);
    check_val("out_valid", out_valid, exp_valid);
    check_val("count", count, m_q.size());
    check_val("out_sel", out_sel, exp_valid && m_half);
    check_val("out_last", out_last, exp_valid && m_half);
    if (exp_valid) begin
      check_val("out_data", out_data, m_half ? m_r[0] : m_q[0]);
    end
    check_val("lo", lo, m_lo);
    check_val("hi", hi, m_hi);
    check_val("dz_flag", dz_flag, m_dzf);
    if (rs) begin
      model_reset();
    end else begin
      lo_acc = exp_valid && rdy && !m_half;
      hi_acc = exp_valid && rdy && m_half;
      if (lo_acc && m_dz[0]) begin
        m_dzf = 1'b1;
      end else if (clr) begin
        m_dzf = 1'b0;
      end
      if (lo_acc) begin
        $display("beat LO data=0x%08h dz=%0d", m_q[0], m_dz[0]);
        m_lo   = m_q[0];
        m_half = 1'b1;
      end
      if (hi_acc) begin
        $display("beat HI data=0x%08h", m_r[0]);
        m_hi = m_r[0];
        void'(m_q.pop_front());
        void'(m_r.pop_front());
        void'(m_dz.pop_front());
        m_half = 1'b0;
      end
      if (v && exp_ready) begin
        $display("push q=0x%08h r=0x%08h dz=%0d", q, r, dz);
        m_q.push_back(dz ? 32'hFFFF_FFFF : q);
        m_r.push_back(r);
        m_dz.push_back(dz);
        n_pushed++;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) begin
      step(1'b0, '0, '0, 1'b0, rdy, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int start;
    logic [31:0] rq;
    logic [31:0] rr;
    model_reset();
    in_valid = 0; in_q = 0; in_r = 0; in_dz = 0;
    out_ready = 0; dz_clear = 0; rst = 1;

    // Reset state
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    check_val("reset_out_data", out_data, 32'h0);
    check_val("reset_count", count, 0);

    // Single pair: LO then HI, then architectural registers
    step(1'b1, 32'h7, 32'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("tp1_lo_beat", out_data, 32'h7);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("tp1_hi_beat", out_data, 32'h2);
    idle(1, 1'b1);
    check_val("tp1_lo", lo, 32'h7);
    check_val("tp1_hi", hi, 32'h2);
    check_val("tp1_count", count, 0);

    // Three back-to-back with a stalled consumer; third is held off
    step(1'b1, 32'h11, 32'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h12, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h13, 32'h23, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("tp2_full_ready", in_ready, 0);
    check_val("tp2_full_count", count, 2);
    start = n_pushed;
    for (int k = 0; k < 10 && n_pushed == start; k++) begin
      step(1'b1, 32'h13, 32'h23, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_val("tp2_third_accepted", n_pushed - start, 1);
    idle(8, 1'b1);
    check_val("tp2_lo", lo, 32'h13);
    check_val("tp2_hi", hi, 32'h23);

    // Divide-by-zero: forced quotient, sticky flag, set beats clear
    step(1'b1, 32'h1234_5678, 32'hA, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("dz_lo_beat", out_data, 32'hFFFF_FFFF);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("dz_hi_beat", out_data, 32'hA);
    check_val("dz_set", dz_flag, 1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h5, 32'hB, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("dz_cleared", dz_flag, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("dz_set_wins", dz_flag, 1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    check_val("dz_clear_alone", dz_flag, 0);

    // Stall between LO and HI beats
    step(1'b1, 32'hCAFE, 32'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b0);
    check_val("stall_hi_beat", out_data, 32'hBEEF);
    check_val("stall_lo", lo, 32'hCAFE);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    check_val("stall_hi", hi, 32'hBEEF);

    // Reset while in SEND_HI with a full FIFO
    step(1'b1, 32'h31, 32'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h32, 32'h42, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("prerst_sel", out_sel, 1);
    idle(1, 1'b0);
    check_val("rst_count", count, 0);
    check_val("rst_ready", in_ready, 1);
    check_val("rst_dz", dz_flag, 0);
    step(1'b1, 32'h51, 32'h61, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("postrst_lo_first", out_data, 32'h51);
    idle(2, 1'b1);

    // Push coinciding with the HI pop at count=1, wrapping the pointers
    step(1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 1; p <= 8; p++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h100 + p, 32'h200 + p, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(0, 1'b1);
    end
    idle(1, 1'b0);
    check_val("wrap_count", count, 1);
    check_val("wrap_hi", hi, 32'h207);
    idle(3, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rq = $urandom;
      rr = $urandom;
      step($urandom_range(0, 9) < 7, rq, rr, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
           $urandom_range(0, 255) == 0);
    end
    idle(6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
